// File: rtl/enoc_node_endpoint_if.sv
// Core-side and network-side handshake bundle for the NoC node endpoint.
interface enoc_node_endpoint_if #(
    parameter int unsigned PACKET_WIDTH = 32,
    parameter int unsigned CNT_WIDTH    = 16
);
    // Core -> endpoint (TX)
    logic [PACKET_WIDTH-1:0] i_tx_data;
    logic                    i_tx_val;
    logic                    o_tx_en;
    // Endpoint -> network node input
    logic [PACKET_WIDTH-1:0] o_net_data;
    logic                    o_net_data_val;
    logic                    i_net_en;
    // Network node output -> endpoint
    logic [PACKET_WIDTH-1:0] i_net_data;
    logic                    i_net_data_val;
    logic                    o_net_en;
    // Endpoint -> core (RX)
    logic [PACKET_WIDTH-1:0] o_rx_data;
    logic                    o_rx_val;
    logic                    i_rx_en;
    // Statistics
    logic [CNT_WIDTH-1:0]    o_tx_count;
    logic [CNT_WIDTH-1:0]    o_rx_count;
    logic [CNT_WIDTH-1:0]    o_misroute_count;

    // Endpoint view
    modport slave (
        input  i_tx_data, i_tx_val, i_net_en, i_net_data, i_net_data_val, i_rx_en,
        output o_tx_en, o_net_data, o_net_data_val, o_net_en, o_rx_data, o_rx_val,
        output o_tx_count, o_rx_count, o_misroute_count
    );

    // Environment view (core plus network)
    modport master (
        output i_tx_data, i_tx_val, i_net_en, i_net_data, i_net_data_val, i_rx_en,
        input  o_tx_en, o_net_data, o_net_data_val, o_net_en, o_rx_data, o_rx_val,
        input  o_tx_count, o_rx_count, o_misroute_count
    );
endinterface

// File: rtl/enoc_node_endpoint.sv
// NoC node endpoint: TX FIFO toward the network, address-filtered RX FIFO
// toward the core, and saturating traffic/misroute counters.
// Every handshake output is a register loaded from next-state occupancy, so
// valid never depends on enable and enable never depends on valid.
module enoc_node_endpoint #(
    parameter int unsigned PACKET_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned NODE_ID      = 0,
    parameter int unsigned TX_DEPTH     = 4,
    parameter int unsigned RX_DEPTH     = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    enoc_node_endpoint_if.slave  bus
);
    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_PW = TX_AW + 1;
    localparam int unsigned RX_PW = RX_AW + 1;

    // TX state
    logic [PACKET_WIDTH-1:0] r_tx_mem [TX_DEPTH];
    logic [TX_PW-1:0]        r_tx_wr, r_tx_rd;
    logic                    r_tx_en;
    logic                    r_net_val;
    logic [PACKET_WIDTH-1:0] r_net_data;

    // RX state
    logic [PACKET_WIDTH-1:0] r_rx_mem [RX_DEPTH];
    logic [RX_PW-1:0]        r_rx_wr, r_rx_rd;
    logic                    r_net_en;
    logic                    r_rx_val;
    logic [PACKET_WIDTH-1:0] r_rx_data;

    // Counters
    logic [CNT_WIDTH-1:0]    r_tx_cnt, r_rx_cnt, r_mis_cnt;

    // Combinational next-state
    logic                    w_tx_push, w_tx_pop;
    logic [TX_PW-1:0]        w_tx_wr_nxt, w_tx_rd_nxt;
    logic                    w_tx_full_nxt, w_tx_empty_nxt;
    logic [PACKET_WIDTH-1:0] w_tx_head_nxt;
    logic                    w_net_acc, w_addr_hit, w_rx_push, w_misroute, w_rx_pop;
    logic [RX_PW-1:0]        w_rx_wr_nxt, w_rx_rd_nxt;
    logic                    w_rx_full_nxt, w_rx_empty_nxt;
    logic [PACKET_WIDTH-1:0] w_rx_head_nxt;

    // TX next pointers, flags and head; the head bypasses the array when the
    // incoming packet lands exactly in the slot that becomes the head
    always_comb begin
        w_tx_push      = bus.i_tx_val && r_tx_en;
        w_tx_pop       = r_net_val && bus.i_net_en;
        w_tx_wr_nxt    = r_tx_wr + TX_PW'(w_tx_push);
        w_tx_rd_nxt    = r_tx_rd + TX_PW'(w_tx_pop);
        w_tx_full_nxt  = (w_tx_wr_nxt[TX_AW] != w_tx_rd_nxt[TX_AW]) &&
                         (w_tx_wr_nxt[TX_AW-1:0] == w_tx_rd_nxt[TX_AW-1:0]);
        w_tx_empty_nxt = (w_tx_wr_nxt == w_tx_rd_nxt);
        w_tx_head_nxt  = r_tx_mem[w_tx_rd_nxt[TX_AW-1:0]];
        if (w_tx_push && (r_tx_wr[TX_AW-1:0] == w_tx_rd_nxt[TX_AW-1:0])) begin
            w_tx_head_nxt = bus.i_tx_data;
        end
        if (w_tx_empty_nxt) begin
            w_tx_head_nxt = '0;
        end
    end

    // RX accept, address filter, next pointers, flags and head
    always_comb begin
        w_net_acc      = bus.i_net_data_val && r_net_en;
        w_addr_hit     = (bus.i_net_data[ADDR_WIDTH-1:0] == ADDR_WIDTH'(NODE_ID));
        w_rx_push      = w_net_acc && w_addr_hit;
        w_misroute     = w_net_acc && !w_addr_hit;
        w_rx_pop       = r_rx_val && bus.i_rx_en;
        w_rx_wr_nxt    = r_rx_wr + RX_PW'(w_rx_push);
        w_rx_rd_nxt    = r_rx_rd + RX_PW'(w_rx_pop);
        w_rx_full_nxt  = (w_rx_wr_nxt[RX_AW] != w_rx_rd_nxt[RX_AW]) &&
                         (w_rx_wr_nxt[RX_AW-1:0] == w_rx_rd_nxt[RX_AW-1:0]);
        w_rx_empty_nxt = (w_rx_wr_nxt == w_rx_rd_nxt);
        w_rx_head_nxt  = r_rx_mem[w_rx_rd_nxt[RX_AW-1:0]];
        if (w_rx_push && (r_rx_wr[RX_AW-1:0] == w_rx_rd_nxt[RX_AW-1:0])) begin
            w_rx_head_nxt = bus.i_net_data;
        end
        if (w_rx_empty_nxt) begin
            w_rx_head_nxt = '0;
        end
    end

    // TX storage array (contents are don't-care once pointers are reset)
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr[TX_AW-1:0]] <= bus.i_tx_data;
        end
    end

    // RX storage array
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr[RX_AW-1:0]] <= bus.i_net_data;
        end
    end

    // TX pointers and registered network-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_en    <= 1'b0;
            r_net_val  <= 1'b0;
            r_net_data <= '0;
        end else begin
            r_tx_wr    <= w_tx_wr_nxt;
            r_tx_rd    <= w_tx_rd_nxt;
            r_tx_en    <= !w_tx_full_nxt;
            r_net_val  <= !w_tx_empty_nxt;
            r_net_data <= w_tx_head_nxt;
        end
    end

    // RX pointers and registered core-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_wr   <= '0;
            r_rx_rd   <= '0;
            r_net_en  <= 1'b0;
            r_rx_val  <= 1'b0;
            r_rx_data <= '0;
        end else begin
            r_rx_wr   <= w_rx_wr_nxt;
            r_rx_rd   <= w_rx_rd_nxt;
            r_net_en  <= !w_rx_full_nxt;
            r_rx_val  <= !w_rx_empty_nxt;
            r_rx_data <= w_rx_head_nxt;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_cnt  <= '0;
            r_rx_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_tx_pop && (r_tx_cnt != '1)) begin
                r_tx_cnt <= r_tx_cnt + CNT_WIDTH'(1);
            end
            if (w_rx_push && (r_rx_cnt != '1)) begin
                r_rx_cnt <= r_rx_cnt + CNT_WIDTH'(1);
            end
            if (w_misroute && (r_mis_cnt != '1)) begin
                r_mis_cnt <= r_mis_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.o_tx_en          = r_tx_en;
    assign bus.o_net_data       = r_net_data;
    assign bus.o_net_data_val   = r_net_val;
    assign bus.o_net_en         = r_net_en;
    assign bus.o_rx_data        = r_rx_data;
    assign bus.o_rx_val         = r_rx_val;
    assign bus.o_tx_count       = r_tx_cnt;
    assign bus.o_rx_count       = r_rx_cnt;
    assign bus.o_misroute_count = r_mis_cnt;

endmodule

// File: tb/tb_enoc_node_endpoint.sv
// Bench for enoc_node_endpoint: directed scenarios plus a random phase,
// all compared against a queue-based model of the endpoint's behaviour.
module tb_enoc_node_endpoint;
    localparam int unsigned PW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned NID   = 3;
    localparam int unsigned TXD   = 4;
    localparam int unsigned RXD   = 4;
    localparam int unsigned CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;

    logic clk;
    logic reset;

    enoc_node_endpoint_if #(.PACKET_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

    enoc_node_endpoint #(
        .PACKET_WIDTH(PW), .ADDR_WIDTH(AW), .NODE_ID(NID),
        .TX_DEPTH(TXD), .RX_DEPTH(RXD), .CNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [PW-1:0] tx_q[$];
    logic [PW-1:0] rx_q[$];
    int tx_cnt, rx_cnt, mis_cnt;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        tx_q.delete();
        rx_q.delete();
        tx_cnt  = 0;
        rx_cnt  = 0;
        mis_cnt = 0;
    endtask

    // Called at a negedge: drive inputs, compare outputs to the model, then
    // advance the model across the next rising edge.
    task automatic step(input logic tv, input logic [PW-1:0] td, input logic ne,
                        input logic nv, input logic [PW-1:0] nd, input logic re);
        bit e_tx_en, e_nval, e_nen, e_rval;
        bit wr, pop, acc, rpop;
        logic [AW-1:0] dest;
        bus.i_tx_val       = tv;
        bus.i_tx_data      = td;
        bus.i_net_en       = ne;
        bus.i_net_data_val = nv;
        bus.i_net_data     = nd;
        bus.i_rx_en        = re;
        e_tx_en = (tx_q.size() < TXD);
        e_nval  = (tx_q.size() != 0);
        e_nen   = (rx_q.size() < RXD);
        e_rval  = (rx_q.size() != 0);
        chk("tx_en",      32'(bus.o_tx_en),        32'(e_tx_en));
        chk("net_val",    32'(bus.o_net_data_val), 32'(e_nval));
        if (e_nval) chk("net_data", bus.o_net_data, tx_q[0]);
        chk("net_en",     32'(bus.o_net_en),       32'(e_nen));
        chk("rx_val",     32'(bus.o_rx_val),       32'(e_rval));
        if (e_rval) chk("rx_data", bus.o_rx_data, rx_q[0]);
        chk("tx_count",   32'(bus.o_tx_count),       32'(tx_cnt));
        chk("rx_count",   32'(bus.o_rx_count),       32'(rx_cnt));
        chk("mis_count",  32'(bus.o_misroute_count), 32'(mis_cnt));
        wr   = tv && e_tx_en;
        pop  = e_nval && ne;
        acc  = nv && e_nen;
        rpop = e_rval && re;
        dest = nd[AW-1:0];
        @(posedge clk);
        if (pop) begin
            void'(tx_q.pop_front());
            tx_cnt = sat(tx_cnt + 1);
        end
        if (wr) tx_q.push_back(td);
        if (rpop) void'(rx_q.pop_front());
        if (acc) begin
            if (dest == AW'(NID)) begin
                rx_q.push_back(nd);
                rx_cnt = sat(rx_cnt + 1);
            end else begin
                mis_cnt = sat(mis_cnt + 1);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ne, input logic re);
        for (int i = 0; i < n; i++) step(1'b0, '0, ne, 1'b0, '0, re);
    endtask

    // Assert reset at a negedge, verify outputs clear at once, release
    task automatic do_reset();
        bus.i_tx_val       = 1'b0;
        bus.i_net_data_val = 1'b0;
        bus.i_net_en       = 1'b0;
        bus.i_rx_en        = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_tx_en",    32'(bus.o_tx_en),          32'd0);
        chk("rst_net_en",   32'(bus.o_net_en),         32'd0);
        chk("rst_net_val",  32'(bus.o_net_data_val),   32'd0);
        chk("rst_rx_val",   32'(bus.o_rx_val),         32'd0);
        chk("rst_net_data", bus.o_net_data,            32'd0);
        chk("rst_rx_data",  bus.o_rx_data,             32'd0);
        chk("rst_tx_cnt",   32'(bus.o_tx_count),       32'd0);
        chk("rst_rx_cnt",   32'(bus.o_rx_count),       32'd0);
        chk("rst_mis_cnt",  32'(bus.o_misroute_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [PW-1:0] pkt(input logic [AW-1:0] dest, input logic [7:0] tag);
        return {20'h0, tag, dest};
    endfunction

    initial begin
        logic [31:0] r;
        logic [AW-1:0] d;
        reset = 1'b1;
        bus.i_tx_val = 1'b0; bus.i_tx_data = '0;
        bus.i_net_en = 1'b0; bus.i_net_data_val = 1'b0; bus.i_net_data = '0;
        bus.i_rx_en = 1'b0;
        model_clear();
        @(negedge clk);

        // Single core write reaches the network one cycle later
        do_reset();
        step(1'b1, 32'h0000_0025, 1'b1, 1'b0, '0, 1'b1);
        chk("t1_net_data", bus.o_net_data, 32'h0000_0025);
        idle(2, 1'b1, 1'b1);
        chk("t1_tx_count", 32'(bus.o_tx_count), 32'd1);
        chk("t1_empty", 32'(bus.o_net_data_val), 32'd0);

        // TX full: fifth write refused, then four leave in order
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, '0, 1'b1);
        chk("t2_full_tx_en", 32'(bus.o_tx_en), 32'd0);
        idle(6, 1'b1, 1'b1);
        chk("t2_tx_count", 32'(bus.o_tx_count), 32'd4);

        // Address filter: dest 3, 5, 3
        do_reset();
        step(1'b0, '0, 1'b1, 1'b1, pkt(4'd3, 8'hA1), 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, pkt(4'd5, 8'hA2), 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, pkt(4'd3, 8'hA3), 1'b1);
        idle(3, 1'b1, 1'b1);
        chk("t3_rx_count", 32'(bus.o_rx_count), 32'd2);
        chk("t3_mis_count", 32'(bus.o_misroute_count), 32'd1);

        // RX backpressure: four accepts then stall; one pop reopens
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1, pkt(4'd3, 8'(8'hB0 + i)), 1'b0);
        chk("t4_net_en_low", 32'(bus.o_net_en), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        chk("t4_net_en_high", 32'(bus.o_net_en), 32'd1);
        idle(5, 1'b1, 1'b1);

        // Steady push/pop on a half-full TX FIFO
        do_reset();
        step(1'b1, 32'hC00, 1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 32'hC01, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 2; i < 12; i++) step(1'b1, 32'hC00 + 32'(i), 1'b1, 1'b0, '0, 1'b1);
        chk("t5_tx_count", 32'(bus.o_tx_count), 32'd10);
        idle(4, 1'b1, 1'b1);

        // Reset mid-operation with three packets in each FIFO
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'hD00 + 32'(i), 1'b0, 1'b1, pkt(4'd3, 8'(8'hD0 + i)), 1'b0);
        chk("t6_net_val_pre", 32'(bus.o_net_data_val), 32'd1);
        chk("t6_rx_val_pre", 32'(bus.o_rx_val), 32'd1);
        do_reset();
        idle(2, 1'b1, 1'b1);

        // Random traffic, long enough to saturate the narrow counters
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            d = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'(NID);
            step(($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, {r[31:AW], d}, $urandom_range(0, 2) != 0);
        end
        idle(8, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/enoc_node_endpoint.md
# enoc_node_endpoint

Node-side endpoint for the electronic NoC. Sits between a processing element (core side) and one node port of the router network, and drives the opposite end of the network's valid/enable node interface. It buffers outbound packets in a TX FIFO and offers them to the network, accepts inbound packets into an RX FIFO under its own enable, and keeps traffic and misroute statistics.

## Interface

Parameters:
- PACKET_WIDTH, 32: packet width in bits. The packet is opaque except for the destination field.
- ADDR_WIDTH, 4: destination node number, held in packet bits [ADDR_WIDTH-1:0].
- NODE_ID, 0: this node's number. Must equal the router number of the attached port.
- TX_DEPTH, 4: TX FIFO entries, power of 2, ≥2.
- RX_DEPTH, 4: RX FIFO entries, power of 2, ≥2.
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- i_tx_data  in  PACKET_WIDTH  packet from the core.
- i_tx_val  in  1  core packet valid.
- o_tx_en  out  1  core may send this cycle.
- o_net_data  out  PACKET_WIDTH  packet to the network node input.
- o_net_data_val  out  1  o_net_data valid.
- i_net_en  in  1  network enables the node to send (the network's o_en for this node).
- i_net_data  in  PACKET_WIDTH  packet from the network node output.
- i_net_data_val  in  1  i_net_data valid.
- o_net_en  out  1  enables the network to send to this node.
- o_rx_data  out  PACKET_WIDTH  packet to the core.
- o_rx_val  out  1  o_rx_data valid.
- i_rx_en  in  1  core accepts this cycle.
- o_tx_count  out  CNT_WIDTH  packets delivered to the network.
- o_rx_count  out  CNT_WIDTH  correctly addressed packets accepted.
- o_misroute_count  out  CNT_WIDTH  accepted packets whose destination ≠ NODE_ID.

## Operation

- Every interface uses the same transfer rule: a transfer occurs on a rising clk edge where valid and enable are both high. Valid must not depend combinationally on enable, and enable must not depend combinationally on valid.
- TX path:
  - o_tx_en = !tx_full. A core write happens on i_tx_val && o_tx_en.
  - o_net_data is the FIFO head. o_net_data_val = !tx_empty.
  - The FIFO pops on o_net_data_val && i_net_en.
  - Push and pop in the same cycle are both performed and the occupancy is unchanged.
  - When the FIFO is full, o_tx_en is low even if a pop happens that cycle. There is no full-bypass.
  - o_net_data and o_net_data_val stay stable until popped.
- RX path:
  - o_net_en = !rx_full, computed from registered occupancy only.
  - On a network transfer, the packet is pushed into the RX FIFO if i_net_data[ADDR_WIDTH-1:0] == NODE_ID and o_rx_count increments.
  - Otherwise the packet is dropped, still acknowledged, and o_misroute_count increments.
  - o_rx_data is the RX FIFO head. o_rx_val = !rx_empty. The FIFO pops on o_rx_val && i_rx_en.
  - Push and pop in the same cycle are both performed.
- Counters:
  - All three reset to 0 and saturate at 2^CNT_WIDTH−1 (no wrap).
  - o_tx_count increments on each network transfer out.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full means the MSBs differ and the rest are equal; empty means the pointers are equal.

## Timing

- Reset values:
  - While reset is high: o_tx_en=0, o_net_en=0, o_net_data_val=0, o_rx_val=0, o_net_data=0, o_rx_data=0, all counters 0.
  - The first cycle after deassertion: o_tx_en=1, o_net_en=1.
- Reset asserted mid-operation immediately flushes both FIFOs. Buffered packets are lost and no transfer completes on that edge.
- TX latency: a packet written at edge n has o_net_data_val high after edge n (one cycle, registered FIFO). Minimum core-to-network latency is 1 cycle.
- RX latency: a packet accepted at edge n has o_rx_val high after edge n.
- Throughput: 1 packet/cycle in each direction when neither side stalls.
- Ordering: FIFO order is preserved per direction. Misrouted packets never reach the core.

## Test plan

- Reset, then a single core write of 0x0000_0025 with i_net_en=1 → o_net_data_val high one cycle later with data 0x0000_0025; o_tx_count=1 after the pop; FIFO empty.
- Hold i_net_en=0 and write 5 packets, TX_DEPTH=4 → o_tx_en falls after the 4th write and the 5th is not accepted. Raise i_net_en → packets 1–4 leave in order, o_tx_en returns high after the first pop, o_tx_count=4.
- NODE_ID=3; network sends dest 3, 5, 3 with i_rx_en=1 → core sees two packets in order; o_rx_count=2, o_misroute_count=1.
- i_rx_en=0; network streams dest-3 packets → o_net_en falls after 4 accepts and no 5th transfer occurs. Pulse i_rx_en for one cycle → o_net_en is high the next cycle.
- Simultaneous push and pop on a half-full TX FIFO for 10 cycles → occupancy constant; outputs match inputs delayed by occupancy, in order.
- Assert reset with 3 packets in each FIFO → o_net_data_val and o_rx_val go low immediately; after release both FIFOs are empty and counters are 0.
